// File: rtl/dcf77_pkg.sv
// DCF77 sync controller shared definitions.
// State encoding, BCD field widths and the BCD minute increment helper.
package dcf77_pkg;

    localparam int ST_W   = 3;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 7;
    localparam int HOUR_W = 6;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t RESET_DEC    = 3'd0;
    localparam state_t WAIT_FIRST   = 3'd1;
    localparam state_t WAIT_CONFIRM = 3'd2;
    localparam state_t LOCKED       = 3'd3;
    localparam state_t HOLDOVER     = 3'd4;

    // Minute-resolution time of day, packed as {hour, minute} in BCD.
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
    } hm_t;

    // Adds one minute to a BCD hour:minute, wrapping 23:59 to 00:00.
    function automatic hm_t bcd_min_inc(
        input logic [HOUR_W-1:0] hour,
        input logic [MIN_W-1:0]  minute
    );
        hm_t r;
        r.hour   = hour;
        r.minute = minute;
        if (minute[3:0] != 4'd9) begin
            r.minute[3:0] = minute[3:0] + 4'd1;
        end else begin
            r.minute[3:0] = 4'd0;
            if (minute[6:4] != 3'd5) begin
                r.minute[6:4] = minute[6:4] + 3'd1;
            end else begin
                r.minute[6:4] = 3'd0;
                if (hour == 6'h23) begin
                    r.hour = 6'h00;
                end else if (hour[3:0] == 4'd9) begin
                    r.hour[3:0] = 4'd0;
                    r.hour[5:4] = hour[5:4] + 2'd1;
                end else begin
                    r.hour[3:0] = hour[3:0] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dcf77_time_counter.sv
// Local time base: 1 s prescaler plus binary seconds and BCD minute/hour.
// Ports: clk, reset (sync, high), run (advance), load + load_hour/load_minute
// (sets time, clears sec and prescaler, wins over tick), sec/minute/hour out,
// tick (prescaler terminal count while running).
module dcf77_time_counter
    import dcf77_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 16000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [MIN_W-1:0]  load_minute,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic              tick
);

    localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLOCK_FREQUENCY - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    hm_t               nxt;

    assign tick   = run && (presc_q == P_LAST);
    assign sec    = sec_q;
    assign minute = min_q;
    assign hour   = hour_q;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        nxt     = bcd_min_inc(hour_q, min_q);
        if (load) begin
            presc_d = '0;
            sec_d   = '0;
            min_d   = load_minute;
            hour_d  = load_hour;
        end else if (tick) begin
            presc_d = '0;
            if (sec_q == 6'd59) begin
                sec_d  = '0;
                min_d  = nxt.minute;
                hour_d = nxt.hour;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// DCF77 sync controller: sequences decoder resets, confirms frames into lock,
// runs holdover on frame loss and raises irq on lock gain/loss.
// Inputs: clk_peri, reset (sync, high), enable, frame_valid + frame_minute/
// frame_hour (BCD), irq_ack. Outputs: dcf_reset, locked, holdover,
// sec (binary), minute/hour (BCD), minute_tick, irq.
module dcf77_sync_ctrl
    import dcf77_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 16000000,
    parameter int RESET_CYCLES    = 16,
    parameter int FRAME_TIMEOUT_S = 125,
    parameter int HOLDOVER_MAX_S  = 3600
) (
    input  logic              clk_peri,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_valid,
    input  logic [MIN_W-1:0]  frame_minute,
    input  logic [HOUR_W-1:0] frame_hour,
    input  logic              irq_ack,
    output logic              dcf_reset,
    output logic              locked,
    output logic              holdover,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic              minute_tick,
    output logic              irq
);

    localparam int TO_MAX = (FRAME_TIMEOUT_S > HOLDOVER_MAX_S) ?
                            FRAME_TIMEOUT_S : HOLDOVER_MAX_S;
    localparam int TW = $clog2(TO_MAX + 1);
    localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(CLOCK_FREQUENCY - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_FRAME = TW'(FRAME_TIMEOUT_S);
    localparam logic [TW-1:0] TO_HOLD  = TW'(HOLDOVER_MAX_S);
    localparam logic [TW-1:0] TO_SAT   = TW'(TO_MAX);

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [PW-1:0] to_presc_q, to_presc_d;
    logic [TW-1:0] to_sec_q, to_sec_d;
    hm_t           cand_q, cand_d;
    logic          locked_q, locked_d;
    logic          holdover_q, holdover_d;
    logic          irq_q, irq_d;
    logic          mtick_q, mtick_d;

    logic          load;
    logic          run;
    logic          tick;
    logic          timed;
    logic          to_clr;
    hm_t           frame;
    hm_t           expected;
    hm_t           cand_next;

    assign frame = {frame_hour, frame_minute};
    assign run   = enable && (state_q == LOCKED || state_q == HOLDOVER);

    dcf77_time_counter #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_time (
        .clk        (clk_peri),
        .reset      (reset),
        .run        (run),
        .load       (load),
        .load_hour  (frame_hour),
        .load_minute(frame_minute),
        .sec        (sec),
        .minute     (minute),
        .hour       (hour),
        .tick       (tick)
    );

    // A frame arrives at the boundary that starts its minute, so past the
    // half-minute the local clock is expected to be one minute behind it.
    always_comb begin
        cand_next = bcd_min_inc(cand_q.hour, cand_q.minute);
        if (sec < 6'd30) begin
            expected = {hour, minute};
        end else begin
            expected = bcd_min_inc(hour, minute);
        end
    end

    // State register
    always_ff @(posedge clk_peri) begin
        if (reset) begin
            state_q <= RESET_DEC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, candidate capture and time load
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        load    = 1'b0;
        if (!enable) begin
            state_d = RESET_DEC;
        end else begin
            unique case (state_q)
                RESET_DEC: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = WAIT_FIRST;
                    end
                end
                WAIT_FIRST: begin
                    if (frame_valid) begin
                        cand_d  = frame;
                        state_d = WAIT_CONFIRM;
                    end
                end
                WAIT_CONFIRM: begin
                    if (frame_valid) begin
                        if (frame == cand_next) begin
                            load    = 1'b1;
                            state_d = LOCKED;
                        end else begin
                            cand_d = frame;
                        end
                    end else if (to_sec_q == TO_FRAME) begin
                        state_d = RESET_DEC;
                    end
                end
                LOCKED, HOLDOVER: begin
                    if (frame_valid) begin
                        if (frame == expected) begin
                            load    = 1'b1;
                            state_d = LOCKED;
                        end else begin
                            cand_d  = frame;
                            state_d = WAIT_CONFIRM;
                        end
                    end else if (state_q == LOCKED &&
                                 to_sec_q == TO_FRAME) begin
                        state_d = HOLDOVER;
                    end else if (state_q == HOLDOVER &&
                                 to_sec_q == TO_HOLD) begin
                        state_d = RESET_DEC;
                    end
                end
                default: state_d = RESET_DEC;
            endcase
        end
    end

    // Outputs and flags
    always_comb begin
        dcf_reset  = (state_q == RESET_DEC);
        locked_d   = (state_d == LOCKED) || (state_d == HOLDOVER);
        holdover_d = (state_d == HOLDOVER);
        irq_d      = (locked_d != locked_q) || (irq_q && !irq_ack);
        mtick_d    = load || (tick && sec == 6'd59);
    end

    // Decoder reset length and the frame/holdover seconds timer.
    // The timer has its own prescaler since the time base is stopped
    // while waiting for confirmation.
    always_comb begin
        rst_cnt_d = '0;
        if (state_q == RESET_DEC && enable && rst_cnt_q != RST_LAST) begin
            rst_cnt_d = rst_cnt_q + RW'(1);
        end
        timed = (state_q == WAIT_CONFIRM) || (state_q == LOCKED) ||
                (state_q == HOLDOVER);
        to_clr     = !timed || frame_valid || (state_d != state_q);
        to_presc_d = to_presc_q;
        to_sec_d   = to_sec_q;
        if (to_clr) begin
            to_presc_d = '0;
            to_sec_d   = '0;
        end else if (to_presc_q == P_LAST) begin
            to_presc_d = '0;
            if (to_sec_q != TO_SAT) begin
                to_sec_d = to_sec_q + TW'(1);
            end
        end else begin
            to_presc_d = to_presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_peri) begin
        if (reset) begin
            rst_cnt_q  <= '0;
            to_presc_q <= '0;
            to_sec_q   <= '0;
            cand_q     <= '0;
            locked_q   <= 1'b0;
            holdover_q <= 1'b0;
            irq_q      <= 1'b0;
            mtick_q    <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            to_presc_q <= to_presc_d;
            to_sec_q   <= to_sec_d;
            cand_q     <= cand_d;
            locked_q   <= locked_d;
            holdover_q <= holdover_d;
            irq_q      <= irq_d;
            mtick_q    <= mtick_d;
        end
    end

    assign locked      = locked_q;
    assign holdover    = holdover_q;
    assign irq         = irq_q;
    assign minute_tick = mtick_q;

endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// Bench for dcf77_sync_ctrl: directed scenarios plus randomized frames,
// all outputs compared each cycle against a time-of-day reference model.
module tb_dcf77_sync_ctrl;

    localparam int CF = 100;
    localparam int RC = 4;
    localparam int FT = 3;
    localparam int HM = 5;

    localparam int S_RD = 0;
    localparam int S_WF = 1;
    localparam int S_WC = 2;
    localparam int S_LK = 3;
    localparam int S_HO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       frame_valid = 1'b0;
    logic [6:0] frame_minute = '0;
    logic [5:0] frame_hour = '0;
    logic       irq_ack = 1'b0;
    logic       dcf_reset, locked, holdover, minute_tick, irq;
    logic [5:0] sec, hour;
    logic [6:0] minute;

    int total = 0;
    int bad = 0;
    int f_mod = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    dcf77_sync_ctrl #(
        .CLOCK_FREQUENCY(CF),
        .RESET_CYCLES   (RC),
        .FRAME_TIMEOUT_S(FT),
        .HOLDOVER_MAX_S (HM)
    ) dut (
        .clk_peri    (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_valid (frame_valid),
        .frame_minute(frame_minute),
        .frame_hour  (frame_hour),
        .irq_ack     (irq_ack),
        .dcf_reset   (dcf_reset),
        .locked      (locked),
        .holdover    (holdover),
        .sec         (sec),
        .minute      (minute),
        .hour        (hour),
        .minute_tick (minute_tick),
        .irq         (irq)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] to_bcd7(input int v);
        return 7'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [5:0] to_bcd6(input int v);
        return 6'((v / 10) * 16 + (v % 10));
    endfunction

    // Reference model: time of day in seconds, frames in minutes of day,
    // timers as plain cycle counts since their last clear.
    int ms = S_RD;
    int rcnt = 0;
    int tcyc = 0;
    int cand = 0;
    int tod = 0;
    int pcyc = 0;
    int m_ns, m_expm;
    bit m_ld, m_oldl, m_tk;
    bit m_locked = 0, m_hold = 0, m_irq = 0, m_tick = 0, m_dcfr = 1;

    function automatic int exp_min(input int t);
        return (t / 60 + (((t % 60) >= 30) ? 1 : 0)) % 1440;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ms = S_RD; rcnt = 0; tcyc = 0; cand = 0; tod = 0; pcyc = 0;
            m_locked = 0; m_hold = 0; m_irq = 0; m_tick = 0; m_dcfr = 1;
        end else begin
            m_ld = 0;
            m_ns = ms;
            m_oldl = (ms == S_LK || ms == S_HO);
            m_tk = enable && m_oldl && (pcyc == CF - 1);
            m_expm = exp_min(tod);
            if (!enable) begin
                m_ns = S_RD;
            end else begin
                case (ms)
                    S_RD: if (rcnt + 1 == RC) m_ns = S_WF;
                    S_WF: if (frame_valid) begin
                        cand = f_mod; m_ns = S_WC;
                    end
                    S_WC: begin
                        if (frame_valid) begin
                            if (f_mod == (cand + 1) % 1440) begin
                                m_ld = 1; m_ns = S_LK;
                            end else cand = f_mod;
                        end else if (tcyc == FT * CF) m_ns = S_RD;
                    end
                    default: begin
                        if (frame_valid) begin
                            if (f_mod == m_expm) begin
                                m_ld = 1; m_ns = S_LK;
                            end else begin
                                cand = f_mod; m_ns = S_WC;
                            end
                        end else if (ms == S_LK && tcyc == FT * CF) m_ns = S_HO;
                        else if (ms == S_HO && tcyc == HM * CF) m_ns = S_RD;
                    end
                endcase
            end
            m_tick = m_ld || (m_tk && (tod % 60) == 59);
            if (m_ld) begin
                tod = f_mod * 60; pcyc = 0;
            end else if (m_tk) begin
                pcyc = 0; tod = (tod + 1) % 86400;
            end else if (enable && m_oldl) begin
                pcyc++;
            end
            if (frame_valid || m_ns != ms ||
                !(ms == S_WC || ms == S_LK || ms == S_HO)) tcyc = 0;
            else tcyc++;
            rcnt = (ms == S_RD && enable && m_ns == S_RD) ? rcnt + 1 : 0;
            m_locked = (m_ns == S_LK || m_ns == S_HO);
            m_hold = (m_ns == S_HO);
            m_irq = (m_locked != m_oldl) || (m_irq && !irq_ack);
            m_dcfr = (m_ns == S_RD);
            ms = m_ns;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_outputs",
                  {6'd0, dcf_reset, locked, holdover, minute_tick, irq,
                   sec, minute, hour},
                  {6'd0, m_dcfr, m_locked, m_hold, m_tick, m_irq,
                   6'(tod % 60), to_bcd7((tod / 60) % 60),
                   to_bcd6(tod / 3600)});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int m);
        f_mod = m;
        frame_hour = to_bcd6(m / 60);
        frame_minute = to_bcd7(m % 60);
        frame_valid = 1'b1;
    endtask

    task automatic send_frame(input int m);
        drive_frame(m);
        step(1);
        frame_valid = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    int n;
    int gap;
    int r;
    int m;
    bit found;

    initial begin
        step(3);
        chk_on = 1;
        check("rst_dcf_reset", dcf_reset, 1);
        check("rst_locked", locked, 0);
        check("rst_irq", irq, 0);
        check("rst_time", {sec, minute, hour}, 0);
        reset = 1'b0;

        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (dcf_reset) n++;
            step(1);
        end
        check("t1_dcf_reset_len", n, 4);
        check("t1_outputs", {locked, holdover, minute_tick, irq}, 0);

        send_frame(12 * 60 + 34);
        step(3);
        send_frame(12 * 60 + 35);
        check("t2_locked", locked, 1);
        check("t2_irq", irq, 1);
        check("t2_hour", hour, 6'h12);
        check("t2_minute", minute, 7'h35);
        check("t2_sec", sec, 0);
        ack();
        check("t2_irq_ack", irq, 0);

        send_frame(23 * 60 + 59);
        step(2);
        check("t3_mismatch_unlock", {locked, irq}, 2'b01);
        send_frame(0);
        check("t3_wrap_lock", {locked, hour, minute}, {1'b1, 13'h0});
        ack();
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if ((tod % 60) == 1 && pcyc == CF - 1) begin
                found = 1;
                break;
            end
            step(1);
        end
        check("t3_sync_found", found, 1);
        send_frame(0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (minute_tick) n++;
            step(1);
        end
        check("t3_one_minute_tick", n, 1);
        check("t3_sec_zero", {locked, sec}, {1'b1, 6'd0});

        step(302);
        check("t4_holdover", {locked, holdover, irq}, 3'b110);
        check("t4_time_runs", sec, 3);
        step(497);
        check("t4_expire", {locked, holdover, irq, dcf_reset}, 4'b0011);
        step(10);
        ack();

        send_frame(10 * 60 + 19);
        step(2);
        send_frame(10 * 60 + 20);
        check("t5_lock", locked, 1);
        ack();
        step(5);
        send_frame(10 * 60 + 45);
        step(1);
        check("t5_unlock", {locked, irq}, 2'b01);
        ack();
        step(3);
        send_frame(10 * 60 + 46);
        check("t5_relock", {locked, hour, minute}, {1'b1, 6'h10, 7'h46});
        ack();

        enable = 1'b0;
        step(1);
        check("t6_disable", {locked, dcf_reset, irq}, 3'b011);
        step(150);
        check("t6_frozen", {sec, hour, minute}, {6'd0, 6'h10, 7'h46});
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (dcf_reset) n++;
            step(1);
        end
        check("t6_dcf_reset_len", n, 4);
        ack();

        gap = 30;
        for (int c = 0; c < 16000; c++) begin
            irq_ack = ($urandom_range(0, 29) == 0);
            if (!enable) begin
                if ($urandom_range(0, 19) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
                enable = 1'b0;
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 7999) == 0) reset = 1'b1;
            if (gap == 0) begin
                r = $urandom_range(0, 9);
                m = $urandom_range(0, 1439);
                if (r < 6) begin
                    if (ms == S_WC) m = (cand + 1) % 1440;
                    else if (ms == S_LK || ms == S_HO) m = exp_min(tod);
                end else if (r == 9) begin
                    m = (tod / 60) % 1440;
                end
                drive_frame(m);
                gap = ($urandom_range(0, 7) == 0) ? $urandom_range(300, 900)
                                                  : $urandom_range(20, 250);
            end else begin
                frame_valid = 1'b0;
                gap--;
            end
            step(1);
        end
        frame_valid = 1'b0;
        irq_ack = 1'b0;
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
